// File: rtl/apb_mem_slave_ws.sv
// APB4 scratch RAM with byte strobes, programmable wait states and optional error response.
// Define APB_MEM_SLV_ERR_EN to flag out-of-range word indices with pslverr; otherwise the index wraps modulo DEPTH.
module apb_mem_slave_ws #(
   parameter int DATA_WD  = 32,
   parameter int ADDR_WD  = 12,
   parameter int DEPTH    = 64,
   parameter int WAIT_CYC = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   psel_i,
   input  logic                   penable_i,
   input  logic                   pwrite_i,
   input  logic [ADDR_WD-1:0]     paddr_i,
   input  logic [DATA_WD-1:0]     pwdata_i,
   input  logic [DATA_WD/8-1:0]   pstrb_i,
   output logic [DATA_WD-1:0]     prdata_o,
   output logic                   pready_o,
   output logic                   pslverr_o
);
   localparam int NB     = DATA_WD / 8;
   localparam int SHIFT  = (NB > 1) ? $clog2(NB) : 0;
   localparam int IDX_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_WD = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(WAIT_CYC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_WD-1:0]   cnt_q, cnt_d;
   logic [DATA_WD-1:0]  mem_q [DEPTH];
   logic [ADDR_WD-1:0]  word_idx_s;
   logic [IDX_WD-1:0]   mem_idx_s;
   logic                hit_s;
   logic                ready_s;
   logic                fire_s;

   assign word_idx_s = paddr_i >> SHIFT;

`ifdef APB_MEM_SLV_ERR_EN
   assign hit_s     = (word_idx_s < ADDR_WD'(DEPTH));
   assign mem_idx_s = IDX_WD'(word_idx_s);
`else
   assign hit_s     = 1'b1;
   assign mem_idx_s = IDX_WD'(word_idx_s % ADDR_WD'(DEPTH));
`endif

   // Completion is purely a function of phase and wait count, so it may rise in the first ACCESS cycle.
   assign ready_s = (state_q == ACCESS) && psel_i && penable_i && (cnt_q == CNT_MAX);
   assign fire_s  = psel_i && penable_i && ready_s;

   // Bus response: read data only while a valid read is in its ACCESS phase, zero otherwise.
   always_comb begin
      pready_o  = ready_s;
      pslverr_o = ready_s && !hit_s;
      if ((state_q == ACCESS) && !pwrite_i && hit_s) begin
         prdata_o = mem_q[mem_idx_s];
      end else begin
         prdata_o = '0;
      end
   end

   // Phase tracking and wait-state counting; losing psel in ACCESS abandons the transfer.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (psel_i) begin
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (ready_s) begin
               state_d = SETUP;
            end else begin
               state_d = ACCESS;
               cnt_d   = (cnt_q != CNT_MAX) ? cnt_q + CNT_WD'(1) : cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Storage array: cleared by reset, byte-masked write on the completing edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (fire_s && pwrite_i && hit_s) begin
         for (int b = 0; b < NB; b++) begin
            if (pstrb_i[b]) begin
               mem_q[mem_idx_s][8*b +: 8] <= pwdata_i[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Randomised self-checking bench: two slaves (no wait states / DEPTH 64, three wait states / DEPTH 48)
// driven by an APB master task and checked every cycle against a word-array memory model.
module tb_apb_mem_slave_ws;
   localparam int NDUT = 2;
`ifdef APB_MEM_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        psel    [NDUT];
   logic        penable [NDUT];
   logic        pwrite  [NDUT];
   logic [11:0] paddr   [NDUT];
   logic [31:0] pwdata  [NDUT];
   logic [3:0]  pstrb   [NDUT];
   logic [31:0] prdata  [NDUT];
   logic        pready  [NDUT];
   logic        pslverr [NDUT];

   int          errors = 0;
   int          checks = 0;
   int          acc_n    [NDUT];
   int          exp_lat  [NDUT];
   bit          cur_wr   [NDUT];
   logic [11:0] cur_addr [NDUT];
   logic [31:0] mdl [NDUT][64];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      apb_mem_slave_ws #(
         .DATA_WD (32),
         .ADDR_WD (12),
         .DEPTH   (g == 0 ? 64 : 48),
         .WAIT_CYC(g == 0 ? 0 : 3)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .psel_i   (psel[g]),
         .penable_i(penable[g]),
         .pwrite_i (pwrite[g]),
         .paddr_i  (paddr[g]),
         .pwdata_i (pwdata[g]),
         .pstrb_i  (pstrb[g]),
         .prdata_o (prdata[g]),
         .pready_o (pready[g]),
         .pslverr_o(pslverr[g])
      );
   end

   function automatic int depth_of(input int d);
      return (d == 0) ? 64 : 48;
   endfunction

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit is_err(input int d, input logic [11:0] a);
      return ERR_EN && (int'(a >> 2) >= depth_of(d));
   endfunction

   function automatic int slot(input int d, input logic [11:0] a);
      return int'(a >> 2) % depth_of(d);
   endfunction

   task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got %08h expected %08h", name, d, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of every slave against the model.
   always @(negedge clk) begin
      bit exp_rdy;
      for (int d = 0; d < NDUT; d++) begin
         if (rst) begin
            chk(d, "rst_pready", {31'd0, pready[d]}, 32'd0);
            chk(d, "rst_pslverr", {31'd0, pslverr[d]}, 32'd0);
            chk(d, "rst_prdata", prdata[d], 32'd0);
         end else begin
            exp_rdy = (acc_n[d] != 0) && (acc_n[d] == exp_lat[d]);
            chk(d, "pready", {31'd0, pready[d]}, {31'd0, exp_rdy});
            if (pready[d] && exp_rdy) begin
               chk(d, "pslverr", {31'd0, pslverr[d]}, {31'd0, is_err(d, cur_addr[d])});
               chk(d, "prdata", prdata[d],
                   (!cur_wr[d] && !is_err(d, cur_addr[d])) ? mdl[d][slot(d, cur_addr[d])] : 32'd0);
            end else if (!pready[d]) begin
               chk(d, "pslverr_idle", {31'd0, pslverr[d]}, 32'd0);
            end
         end
      end
   end

   task automatic clear_model();
      for (int d = 0; d < NDUT; d++) begin
         for (int w = 0; w < 64; w++) begin
            mdl[d][w] = 32'd0;
         end
      end
   endtask

   task automatic idle(input int d, input int n);
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One APB transfer; abort_at>0 drops psel (or pulses reset) after that many ACCESS cycles.
   task automatic xfer(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit b2b, input int abort_at, input bit abort_rst,
                       output logic [31:0] rdata, output bit err, output int lat);
      bit done;
      bit got;
      rdata = 32'd0;
      err   = 1'b0;
      lat   = 0;
      done  = 1'b0;
      got   = 1'b0;
      psel[d]     = 1'b1;
      penable[d]  = 1'b0;
      pwrite[d]   = wr;
      paddr[d]    = addr;
      pwdata[d]   = data;
      pstrb[d]    = strb;
      cur_wr[d]   = wr;
      cur_addr[d] = addr;
      exp_lat[d]  = wait_of(d) + (b2b ? 1 : 2);
      @(posedge clk);
      #1;
      penable[d] = 1'b1;
      acc_n[d]   = 1;
      while (!done) begin
         @(negedge clk);
         got = pready[d];
         if (got) begin
            rdata = prdata[d];
            err   = pslverr[d];
         end
         @(posedge clk);
         #1;
         if (got) begin
            if (wr && !is_err(d, addr)) begin
               for (int b = 0; b < 4; b++) begin
                  if (strb[b]) mdl[d][slot(d, addr)][8*b +: 8] = data[8*b +: 8];
               end
            end
            lat      = acc_n[d];
            acc_n[d] = 0;
            done     = 1'b1;
         end else if ((abort_at != 0) && (acc_n[d] == abort_at)) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            acc_n[d]   = 0;
            done       = 1'b1;
            if (abort_rst) begin
               rst = 1'b1;
               clear_model();
            end
         end else if (acc_n[d] >= exp_lat[d] + 4) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: no pready after %0d access cycles, expected at %0d",
                     d, acc_n[d], exp_lat[d]);
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            acc_n[d]   = 0;
            done       = 1'b1;
         end else begin
            acc_n[d]++;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lt;
      int          held;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 12'd0;
         pwdata[d] = 32'd0; pstrb[d] = 4'd0; acc_n[d] = 0; exp_lat[d] = 0;
         cur_wr[d] = 1'b0; cur_addr[d] = 12'd0;
      end
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Full write/read with no wait states: ready in the first slave ACCESS cycle.
      xfer(0, 1'b1, 12'h010, 32'h12345678, 4'hF, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "lat_ws0", 32'(lt), 32'd2);
      idle(0, 3);
      xfer(0, 1'b0, 12'h010, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "rd_full", rd, 32'h12345678);
      idle(0, 3);

      // Byte strobes.
      xfer(0, 1'b1, 12'h008, 32'h11223344, 4'hF, 1'b0, 0, 1'b0, rd, er, lt);
      idle(0, 3);
      xfer(0, 1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 1'b0, 0, 1'b0, rd, er, lt);
      idle(0, 3);
      xfer(0, 1'b0, 12'h008, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "rd_strb5", rd, 32'h11BB33DD);
      idle(0, 3);
      xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "strb0_err", {31'd0, er}, 32'd0);
      idle(0, 3);
      xfer(0, 1'b0, 12'h008, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "rd_strb0", rd, 32'h11BB33DD);
      idle(0, 3);

      // Three wait states, then back-to-back transfers with psel held.
      xfer(1, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0, rd, er, lt);
      chk(1, "lat_ws3_idle", 32'(lt), 32'd5);
      xfer(1, 1'b1, 12'h024, 32'h0BADF00D, 4'hF, 1'b1, 0, 1'b0, rd, er, lt);
      chk(1, "lat_ws3_b2b", 32'(lt), 32'd4);
      xfer(1, 1'b0, 12'h020, 32'd0, 4'h0, 1'b1, 0, 1'b0, rd, er, lt);
      chk(1, "rd_b2b", rd, 32'hCAFEF00D);
      idle(1, 3);

      // Out-of-range index 64 on the DEPTH=64 slave.
      xfer(0, 1'b1, 12'h100, 32'h5A5A5A5A, 4'hF, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "oor_wr_err", {31'd0, er}, {31'd0, ERR_EN});
      idle(0, 3);
      xfer(0, 1'b0, 12'h100, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "oor_rd", rd, ERR_EN ? 32'd0 : 32'h5A5A5A5A);
      idle(0, 3);
      xfer(0, 1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(0, "oor_idx0", rd, ERR_EN ? 32'd0 : 32'h5A5A5A5A);
      idle(0, 3);

      // psel dropped during a wait state: no write, next transfer waits in full.
      xfer(1, 1'b1, 12'h020, 32'h77777777, 4'hF, 1'b0, 2, 1'b0, rd, er, lt);
      idle(1, 3);
      xfer(1, 1'b0, 12'h020, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(1, "abort_lat", 32'(lt), 32'd5);
      chk(1, "abort_rd", rd, 32'hCAFEF00D);
      idle(1, 3);

      // Reset pulse in the middle of a write to idx 3.
      xfer(1, 1'b1, 12'h00C, 32'h12121212, 4'hF, 1'b0, 0, 1'b0, rd, er, lt);
      idle(1, 3);
      xfer(1, 1'b1, 12'h00C, 32'hDEADBEEF, 4'hF, 1'b0, 3, 1'b1, rd, er, lt);
      @(posedge clk);
      #1;
      rst = 1'b0;
      xfer(1, 1'b0, 12'h00C, 32'd0, 4'h0, 1'b0, 0, 1'b0, rd, er, lt);
      chk(1, "rst_rd_idx3", rd, 32'd0);
      chk(1, "rst_rd_err", {31'd0, er}, 32'd0);
      chk(1, "rst_rd_lat", 32'(lt), 32'd5);
      idle(1, 3);

      // Randomised traffic across both slaves, mixing idle gaps and back-to-back transfers.
      held = -1;
      for (int i = 0; i < 400; i++) begin
         int          d;
         int          idx;
         bit          b2b;
         bit          wr;
         logic [11:0] a;
         logic [3:0]  s;
         d   = int'($urandom_range(0, 1));
         b2b = (held == d) && ($urandom_range(0, 1) == 1);
         if ((held >= 0) && !b2b) idle(held, int'($urandom_range(2, 4)));
         idx = int'($urandom_range(0, depth_of(d) + 3));
         a   = 12'(idx * 4 + int'($urandom_range(0, 3)));
         wr  = ($urandom_range(0, 1) == 1);
         s   = 4'($urandom);
         xfer(d, wr, a, $urandom, s, b2b, 0, 1'b0, rd, er, lt);
         held = d;
      end
      if (held >= 0) idle(held, 3);

      // Read back every word of both slaves.
      for (int d = 0; d < NDUT; d++) begin
         for (int w = 0; w < depth_of(d); w++) begin
            xfer(d, 1'b0, 12'(w * 4), 32'd0, 4'h0, (w != 0), 0, 1'b0, rd, er, lt);
         end
         idle(d, 3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
